// File: rtl/fpu_pkg.sv
// Shared FPU types: finv latency, result record and issue tag.
package fpu_pkg;

  localparam int FINV_LAT = 2;
  // Tag ids are fixed-width so the struct stays unparameterised; this caps requesters at 16.
  localparam int ID_W     = 4;

  typedef struct packed {
    logic [31:0] data;
    logic        ovf;
    logic        udf;
  } result_t;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/finv_arbiter_finv.sv
// Single-precision reciprocal, round-to-nearest-even, denormals flushed, LAT-stage output pipe.
module finv
  import fpu_pkg::*;
#(
  parameter int LAT = FINV_LAT
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] src,
  output logic [31:0] dest,
  output logic        ovf,
  output logic        udf
);

  localparam logic [49:0] ONE_Q49 = 50'd1 << 49;

  logic              sgn;
  logic [7:0]        exp_in;
  logic [22:0]       frac;
  logic [24:0]       quo;
  logic              sticky;
  logic              rnd_up;
  logic signed [9:0] exp_res;
  logic [30:0]       mag;
  result_t           res_c;
  result_t           pipe_q [LAT];

  always_comb begin
    sgn    = src[31];
    exp_in = src[30:23];
    frac   = src[22:0];
    // 2^49/sig has its hidden one at bit 25 (dropped), 23 mantissa bits, then guard and round.
    quo    = 25'(ONE_Q49 / {26'd0, 1'b1, frac});
    sticky = (ONE_Q49 % {26'd0, 1'b1, frac}) != 50'd0;
    rnd_up = quo[1] & (quo[0] | sticky | quo[2]);
    if (frac == 23'd0) exp_res = 10'sd254 - $signed({2'b00, exp_in});
    else               exp_res = 10'sd253 - $signed({2'b00, exp_in});
    mag = {exp_res[7:0], quo[24:2]} + {30'd0, rnd_up};

    res_c = '0;
    if (exp_in == 8'd0) begin
      res_c.data = {sgn, 8'hFF, 23'd0};
      res_c.ovf  = 1'b1;
    end else if (exp_in == 8'hFF) begin
      res_c.data = (frac != 23'd0) ? 32'h7FC0_0000 : {sgn, 31'd0};
    end else if (exp_res <= 10'sd0) begin
      res_c.data = {sgn, 31'd0};
      res_c.udf  = 1'b1;
    end else begin
      res_c.data = {sgn, mag};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < LAT; k++) pipe_q[k] <= '0;
    end else begin
      pipe_q[0] <= res_c;
      for (int k = 1; k < LAT; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign dest = pipe_q[LAT-1].data;
  assign ovf  = pipe_q[LAT-1].ovf;
  assign udf  = pipe_q[LAT-1].udf;

endmodule

// File: rtl/finv_arbiter.sv
// Round-robin sharing of one finv unit across N_REQ requesters with credit-checked result FIFOs.
module finv_arbiter
  import fpu_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int LAT   = FINV_LAT,
  parameter int DEPTH = 3
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0][31:0] req_src,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [N_REQ-1:0][31:0] rsp_data,
  output logic [N_REQ-1:0]       rsp_ovf,
  output logic [N_REQ-1:0]       rsp_udf,
  input  logic [N_REQ-1:0]       rsp_ready
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [N_REQ-1:0]            elig, pop, gnt, wr_en;
  logic [IDX_W-1:0]            rr_ptr, gnt_idx;
  logic                        gnt_any;
  logic [31:0]                 finv_src, finv_dest;
  logic                        finv_ovf, finv_udf;
  logic [N_REQ-1:0][CNT_W-1:0] occ, cnt;
  logic [N_REQ-1:0][PTR_W-1:0] wr_ptr, rd_ptr;
  tag_t                        tag_q [LAT];
  result_t                     mem [N_REQ][DEPTH];
  result_t                     wr_res;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A pop in the same cycle frees a credit, so a full requester can still issue at full rate.
  for (genvar g = 0; g < N_REQ; g++) begin : g_req
    assign rsp_valid[g] = cnt[g] != '0;
    assign pop[g]       = rsp_valid[g] & rsp_ready[g];
    assign elig[g]      = req_valid[g] & ((occ[g] < CNT_W'(DEPTH)) | pop[g]);
    assign wr_en[g]     = tag_q[LAT-1].valid && (tag_q[LAT-1].id == ID_W'(g));
    assign rsp_data[g]  = rsp_valid[g] ? mem[g][rd_ptr[g]].data : 32'd0;
    assign rsp_ovf[g]   = rsp_valid[g] & mem[g][rd_ptr[g]].ovf;
    assign rsp_udf[g]   = rsp_valid[g] & mem[g][rd_ptr[g]].udf;
  end

  always_comb begin
    logic [IDX_W-1:0] cand;
    gnt      = '0;
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    cand     = '0;
    finv_src = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr) + 1 + k) % N_REQ);
      for (int i = 0; i < N_REQ; i++) begin
        if (!gnt_any && elig[i] && (cand == IDX_W'(i))) begin
          gnt_any = 1'b1;
          gnt_idx = IDX_W'(i);
          gnt[i]  = 1'b1;
        end
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) finv_src = req_src[i];
    end
  end

  assign req_ready = gnt;

  finv #(.LAT(LAT)) u_finv (
    .clk  (clk),
    .rstn (rstn),
    .src  (finv_src),
    .dest (finv_dest),
    .ovf  (finv_ovf),
    .udf  (finv_udf)
  );

  assign wr_res = '{data: finv_dest, ovf: finv_ovf, udf: finv_udf};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr <= IDX_W'(N_REQ - 1);
      occ    <= '0;
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int k = 0; k < LAT; k++) tag_q[k] <= '0;
    end else begin
      if (gnt_any) rr_ptr <= gnt_idx;
      tag_q[0].valid <= gnt_any;
      tag_q[0].id    <= ID_W'(gnt_idx);
      for (int k = 1; k < LAT; k++) tag_q[k] <= tag_q[k-1];
      for (int i = 0; i < N_REQ; i++) begin
        if (gnt[i] && !pop[i])      occ[i] <= occ[i] + 1'b1;
        else if (!gnt[i] && pop[i]) occ[i] <= occ[i] - 1'b1;
        if (wr_en[i] && !pop[i])      cnt[i] <= cnt[i] + 1'b1;
        else if (!wr_en[i] && pop[i]) cnt[i] <= cnt[i] - 1'b1;
        if (wr_en[i]) wr_ptr[i] <= ptr_inc(wr_ptr[i]);
        if (pop[i])   rd_ptr[i] <= ptr_inc(rd_ptr[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (wr_en[i]) mem[i][wr_ptr[i]] <= wr_res;
    end
  end

endmodule

// File: tb/tb_finv_arbiter.sv
// Directed and random checks of finv_arbiter against a real-arithmetic reciprocal model.
module tb_finv_arbiter;

  logic            clk;
  logic            rstn;
  logic [1:0]      req_valid;
  logic [1:0][31:0] req_src;
  logic [1:0]      req_ready;
  logic [1:0]      rsp_valid;
  logic [1:0][31:0] rsp_data;
  logic [1:0]      rsp_ovf;
  logic [1:0]      rsp_udf;
  logic [1:0]      rsp_ready;

  int n_cmp = 0;
  int n_err = 0;

  logic [33:0] q0[$];
  logic [33:0] q1[$];

  finv_arbiter dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_src   (req_src),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_ovf   (rsp_ovf),
    .rsp_udf   (rsp_udf),
    .rsp_ready (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] s0, input logic [31:0] s1,
                       input logic [1:0] rr);
    req_valid  = v;
    req_src[0] = s0;
    req_src[1] = s1;
    rsp_ready  = rr;
    #1;
  endtask

  // Reciprocal via double precision, then RNE down to single; returns {data, ovf, udf}.
  function automatic logic [33:0] finv_model(input logic [31:0] s);
    logic        sg;
    logic [7:0]  e;
    logic [22:0] f;
    logic [63:0] rb;
    logic [22:0] m;
    logic [30:0] mag;
    real         d;
    int          ex;
    sg = s[31];
    e  = s[30:23];
    f  = s[22:0];
    if (e == 8'd0) return {sg, 8'hFF, 23'd0, 2'b10};
    if (e == 8'hFF) return (f != 23'd0) ? {32'h7FC0_0000, 2'b00} : {sg, 31'd0, 2'b00};
    d  = $bitstoreal({1'b0, 11'(e) + 11'd896, f, 29'd0});
    rb = $realtobits(1.0 / d);
    ex = int'(rb[62:52]) - 1023 + 127;
    if (ex <= 0) return {sg, 31'd0, 2'b01};
    m   = rb[51:29];
    mag = {8'(ex), m};
    if (rb[28] && ((|rb[27:0]) || m[0])) mag = mag + 31'd1;
    return {sg, mag, 2'b00};
  endfunction

  // Scoreboard and invariant monitor, sampled mid-cycle.
  always @(negedge clk) begin
    logic [33:0] got;
    logic [33:0] want;
    int          sz;
    if (!rstn) begin
      q0.delete();
      q1.delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        got = {rsp_data[i], rsp_ovf[i], rsp_udf[i]};
        if (!rsp_valid[i]) begin
          check("rsp_idle_zero", 64'(got), 64'd0);
        end else if (rsp_ready[i]) begin
          sz = (i == 0) ? q0.size() : q1.size();
          if (sz == 0) begin
            check("sb_underrun", 64'(sz), 64'd1);
          end else begin
            if (i == 0) want = q0.pop_front();
            else        want = q1.pop_front();
            check((i == 0) ? "sb_rsp0" : "sb_rsp1", 64'(got), 64'(want));
          end
        end
        if (req_valid[i] && req_ready[i]) begin
          if (i == 0) q0.push_back(finv_model(req_src[i]));
          else        q1.push_back(finv_model(req_src[i]));
        end
        if (dut.wr_en[i]) check("wr_while_full", 64'(dut.cnt[i] < 3), 64'd1);
      end
      check("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
      check("ready_without_valid", 64'(req_ready & ~req_valid), 64'd0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [31:0] vals1 [3];
  logic [31:0] spec_src [4];
  logic [33:0] spec_exp [4];
  int          accepts;
  int          cycles;

  initial begin
    vals1[0] = 32'h4000_0000;  vals1[1] = 32'h4080_0000;  vals1[2] = 32'h3F00_0000;
    spec_src[0] = 32'h0000_0000; spec_exp[0] = {32'h7F80_0000, 2'b10};
    spec_src[1] = 32'h7F00_0000; spec_exp[1] = {32'h0000_0000, 2'b01};
    spec_src[2] = 32'hFF80_0000; spec_exp[2] = {32'h8000_0000, 2'b00};
    spec_src[3] = 32'h3FC0_0000; spec_exp[3] = {32'h3F2A_AAAB, 2'b00};

    // Reset state
    rstn = 1'b0;
    drive(2'b00, 32'd0, 32'd0, 2'b00);
    repeat (3) tick();
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_rsp_flags", 64'({rsp_ovf, rsp_udf}), 64'd0);
    check("rst_occ", 64'(dut.occ), 64'd0);
    tick();
    rstn = 1'b1;
    #1;
    check("rel_rsp_valid", 64'(rsp_valid), 64'd0);

    // Single operand 2.0 on requester 0
    tick(); drive(2'b01, 32'h4000_0000, 32'd0, 2'b11);
    check("single_ready", 64'(req_ready), 64'b01);
    tick(); drive(2'b00, 32'd0, 32'd0, 2'b11);
    check("single_c1", 64'(rsp_valid), 64'd0);
    tick(); check("single_c2", 64'(rsp_valid), 64'd0);
    tick();
    check("single_c3_valid", 64'(rsp_valid), 64'b01);
    check("single_c3_data", 64'(rsp_data[0]), 64'h3F00_0000);
    check("single_c3_flags", 64'({rsp_ovf[0], rsp_udf[0]}), 64'd0);
    tick(); check("single_c4", 64'(rsp_valid), 64'd0);

    // Alternating grants with both requesters streaming
    tick(); drive(2'b10, 32'd0, 32'h4080_0000, 2'b11);
    check("alt_pre_ready", 64'(req_ready), 64'b10);
    for (int k = 0; k < 6; k++) begin
      tick(); drive(2'b11, 32'h3F80_0000, 32'h4080_0000, 2'b11);
      check("alt_ready", 64'(req_ready), (k % 2 == 0) ? 64'b01 : 64'b10);
      if (k >= 2) check("alt_rsp_valid", 64'(rsp_valid), (k % 2 == 0) ? 64'b10 : 64'b01);
      if (k == 2) check("alt_data1", 64'(rsp_data[1]), 64'h3E80_0000);
      if (k == 3) check("alt_data0", 64'(rsp_data[0]), 64'h3F80_0000);
    end
    tick(); drive(2'b00, 32'd0, 32'd0, 2'b11);
    repeat (4) tick();
    check("alt_drained", 64'(rsp_valid), 64'd0);

    // Stalled consumer 1: three credits, then requester 0 alone at full rate
    for (int k = 0; k < 12; k++) begin
      tick(); drive(2'b11, 32'h3F80_0000, vals1[(k < 6) ? k / 2 : 2], 2'b01);
      check("stall_ready", 64'(req_ready), (k < 6) ? ((k % 2 == 0) ? 64'b01 : 64'b10) : 64'b01);
      if (k == 9 || k == 10) check("occ0_full_issue_pop", 64'(dut.occ[0]), 64'd3);
      if (k == 11) begin
        check("stall_rsp1_valid", 64'(rsp_valid[1]), 64'd1);
        check("stall_rsp1_head", 64'(rsp_data[1]), 64'h3F00_0000);
        check("stall_occ1", 64'(dut.occ[1]), 64'd3);
      end
    end
    tick(); drive(2'b00, 32'd0, 32'd0, 2'b11);
    check("drain1_0", 64'(rsp_data[1]), 64'h3F00_0000);
    tick(); check("drain1_1", 64'(rsp_data[1]), 64'h3E80_0000);
    tick(); check("drain1_2", 64'(rsp_data[1]), 64'h4000_0000);
    tick(); check("drain1_empty", 64'(rsp_valid[1]), 64'd0);
    repeat (3) tick();
    check("drain_all", 64'(rsp_valid), 64'd0);

    // Special operands back-to-back on requester 0
    for (int k = 0; k < 7; k++) begin
      tick();
      if (k < 4) begin
        drive(2'b01, spec_src[k], 32'd0, 2'b11);
        check("spec_ready", 64'(req_ready), 64'b01);
      end else begin
        drive(2'b00, 32'd0, 32'd0, 2'b11);
      end
      if (k >= 3) begin
        check("spec_valid", 64'(rsp_valid), 64'b01);
        check("spec_result", 64'({rsp_data[0], rsp_ovf[0], rsp_udf[0]}), 64'(spec_exp[k-3]));
      end
    end
    tick(); check("spec_done", 64'(rsp_valid), 64'd0);

    // Reset with two operations in flight
    tick(); drive(2'b11, 32'h4000_0000, 32'h4000_0000, 2'b11);
    tick(); drive(2'b11, 32'h4000_0000, 32'h4000_0000, 2'b11);
    tick(); drive(2'b00, 32'd0, 32'd0, 2'b11);
    rstn = 1'b0;
    #1;
    check("midrst_valid", 64'(rsp_valid), 64'd0);
    tick();
    rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("post_rst_quiet", 64'(rsp_valid), 64'd0);
    end
    tick(); drive(2'b11, 32'h4000_0000, 32'h3F80_0000, 2'b11);
    check("post_rst_rr", 64'(req_ready), 64'b01);
    tick(); drive(2'b00, 32'd0, 32'd0, 2'b11);
    check("post_rst_c1", 64'(rsp_valid), 64'd0);
    tick(); check("post_rst_c2", 64'(rsp_valid), 64'd0);
    tick();
    check("post_rst_c3_valid", 64'(rsp_valid), 64'b01);
    check("post_rst_c3_data", 64'({rsp_data[0], rsp_ovf[0], rsp_udf[0]}), {30'd0, 32'h3F00_0000, 2'b00});
    tick(); check("post_rst_c4", 64'(rsp_valid), 64'd0);

    // Random traffic against the scoreboard
    accepts = 0;
    cycles  = 0;
    while (accepts < 100 && cycles < 3000) begin
      tick();
      drive(2'($urandom_range(0, 3)), $urandom, $urandom, 2'($urandom_range(0, 3)));
      accepts += $countones(req_valid & req_ready);
      cycles++;
    end
    check("rand_accepts", 64'(accepts >= 100), 64'd1);
    tick(); drive(2'b00, 32'd0, 32'd0, 2'b11);
    repeat (10) tick();
    check("rand_q0_empty", 64'(q0.size()), 64'd0);
    check("rand_q1_empty", 64'(q1.size()), 64'd0);
    check("rand_rsp_idle", 64'(rsp_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
